// File: rtl/frame_capture_pkg.sv
// Shared constants for the frame capture bank: status byte layout, read-map offsets
// and the default header that qualifies a thermostat frame.
package frame_capture_pkg;

    localparam int STAT_OVERRUN = 7;
    localparam int STAT_PENDING = 6;
    localparam int STAT_FRESH   = 5;
    localparam int STAT_FREEZE  = 4;

    localparam logic [63:0] DEFAULT_KNOWN_HEADER = 64'hAAAAAAAA_0DFFFFFE;

    // The status and reject-count bytes sit directly after the payload bytes.
    function automatic int addr_status(input int payload_bytes);
        return payload_bytes;
    endfunction

    function automatic int addr_reject(input int payload_bytes);
        return payload_bytes + 1;
    endfunction

endpackage

// File: rtl/frame_event_detect.sv
// One event per rising edge of the decoder's frame_full level, qualified by a
// header compare into accept or reject.
module frame_event_detect
    import frame_capture_pkg::*;
#(
    parameter int                     HEADER_BITS  = 64,
    parameter logic [HEADER_BITS-1:0] KNOWN_HEADER = HEADER_BITS'(DEFAULT_KNOWN_HEADER)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_full,
    input  logic [HEADER_BITS-1:0] frame_header,
    output logic                   accept,
    output logic                   reject
);

    logic full_q;
    logic rise;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) full_q <= 1'b0;
        else        full_q <= frame_full;
    end

    assign rise   = frame_full & ~full_q;
    assign accept = rise & (frame_header == KNOWN_HEADER);
    assign reject = rise & ~accept;

endmodule

// File: rtl/frame_capture_bank.sv
// Captures qualified decoder frames into a byte-addressable bank with a
// freeze/pending double buffer, status flags, counters and a registered read port.
module frame_capture_bank
    import frame_capture_pkg::*;
#(
    parameter int                     PAYLOAD_BYTES = 4,
    parameter int                     HEADER_BITS   = 64,
    parameter logic [HEADER_BITS-1:0] KNOWN_HEADER  = HEADER_BITS'(DEFAULT_KNOWN_HEADER),
    parameter int                     ADDR_W        = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       frame_full,
    input  logic [HEADER_BITS-1:0]     frame_header,
    input  logic [PAYLOAD_BYTES*8-1:0] frame_payload,
    input  logic                       freeze,
    input  logic                       ack,
    input  logic [ADDR_W-1:0]          address,
    output logic [7:0]                 parallel_out,
    output logic                       fresh,
    output logic                       overrun
);

    localparam int                PW          = PAYLOAD_BYTES * 8;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(addr_status(PAYLOAD_BYTES));
    localparam logic [ADDR_W-1:0] REJECT_ADDR = ADDR_W'(addr_reject(PAYLOAD_BYTES));

    logic          accept, reject;
    logic [PW-1:0] visible_q, visible_d;
    logic [PW-1:0] pending_bank_q, pending_bank_d;
    logic          pending_q, pending_d;
    logic          fresh_q, fresh_d;
    logic          overrun_q, overrun_d;
    logic [3:0]    frame_count_q;
    logic [7:0]    reject_count_q;
    logic [7:0]    visible_byte, status_byte, read_d;

    frame_event_detect #(
        .HEADER_BITS  (HEADER_BITS),
        .KNOWN_HEADER (KNOWN_HEADER)
    ) u_event_detect (
        .clock        (clock),
        .reset        (reset),
        .frame_full   (frame_full),
        .frame_header (frame_header),
        .accept       (accept),
        .reject       (reject)
    );

    // Set conditions are applied after ack so that a coincident set wins.
    // NOTE: every combinational output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        visible_d      = visible_q;
        pending_bank_d = pending_bank_q;
        pending_d      = pending_q;
        fresh_d        = fresh_q;
        overrun_d      = overrun_q;
        if (ack) begin
            fresh_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (accept) begin
            if (pending_q) overrun_d = 1'b1;
            if (freeze) begin
                pending_bank_d = frame_payload;
                pending_d      = 1'b1;
            end else begin
                visible_d = frame_payload;
                pending_d = 1'b0;
                fresh_d   = 1'b1;
            end
        end else if (!freeze && pending_q) begin
            visible_d = pending_bank_q;
            pending_d = 1'b0;
            fresh_d   = 1'b1;
        end
    end

    // NOTE: the banks are reset along with the flags because the microcontroller
    // may read them before the first frame and must see zeros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            visible_q      <= '0;
            pending_bank_q <= '0;
            pending_q      <= 1'b0;
            fresh_q        <= 1'b0;
            overrun_q      <= 1'b0;
            frame_count_q  <= 4'd0;
            reject_count_q <= 8'd0;
            parallel_out   <= 8'h00;
        end else begin
            visible_q      <= visible_d;
            pending_bank_q <= pending_bank_d;
            pending_q      <= pending_d;
            fresh_q        <= fresh_d;
            overrun_q      <= overrun_d;
            parallel_out   <= read_d;
            if (accept) frame_count_q <= frame_count_q + 4'd1;
            if (reject && reject_count_q != 8'hFF) reject_count_q <= reject_count_q + 8'd1;
        end
    end

    always_comb begin
        visible_byte = 8'h00;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (int'(address) == k) visible_byte = visible_q[k*8 +: 8];
        end
    end

    always_comb begin
        status_byte               = 8'h00;
        status_byte[STAT_OVERRUN] = overrun_q;
        status_byte[STAT_PENDING] = pending_q;
        status_byte[STAT_FRESH]   = fresh_q;
        status_byte[STAT_FREEZE]  = freeze;
        status_byte[3:0]          = frame_count_q;
    end

    // Read mux sees pre-edge state, so a read racing an update returns the old byte.
    always_comb begin
        read_d = 8'h00;
        if (int'(address) < PAYLOAD_BYTES) read_d = visible_byte;
        else if (address == STATUS_ADDR)   read_d = status_byte;
        else if (address == REJECT_ADDR)   read_d = reject_count_q;
    end

    assign fresh   = fresh_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_frame_capture_bank.sv
// Directed self-checking bench for frame_capture_bank in its default build.
module tb_frame_capture_bank;

    localparam logic [63:0] GOOD_HDR = 64'hAAAAAAAA_0DFFFFFE;
    localparam logic [63:0] BAD_HDR  = 64'hAAAAAAAA_0DFFFFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_full;
    logic [63:0] frame_header;
    logic [31:0] frame_payload;
    logic        freeze;
    logic        ack;
    logic [2:0]  address;
    logic [7:0]  parallel_out;
    logic        fresh;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    frame_capture_bank dut (
        .clock         (clock),
        .reset         (reset),
        .frame_full    (frame_full),
        .frame_header  (frame_header),
        .frame_payload (frame_payload),
        .freeze        (freeze),
        .ack           (ack),
        .address       (address),
        .parallel_out  (parallel_out),
        .fresh         (fresh),
        .overrun       (overrun)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_frame(input logic [63:0] hdr, input logic [31:0] pay);
        @(negedge clock);
        frame_full    = 1'b1;
        frame_header  = hdr;
        frame_payload = pay;
        @(negedge clock);
        frame_full = 1'b0;
        @(negedge clock);
    endtask

    task automatic read_addr(input logic [2:0] a, output logic [7:0] d);
        @(negedge clock);
        address = a;
        @(negedge clock);
        d = parallel_out;
    endtask

    task automatic pulse_ack();
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
    endtask

    task automatic expect_byte(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        read_addr(a, d);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("FAIL %s: addr %0d got %h expected %h", name, a, d, exp);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_full = 1'b0; frame_header = '0; frame_payload = '0;
        freeze = 1'b0; ack = 1'b0; address = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int a = 0; a < 8; a++) expect_byte("reset_read", 3'(a), 8'h00);
        expect_bit("reset_fresh", fresh, 1'b0);
        expect_bit("reset_overrun", overrun, 1'b0);
    endtask

    task automatic test_capture();
        send_frame(GOOD_HDR, 32'h12345678);
        expect_byte("cap_b0", 3'd0, 8'h78);
        // Latency: new address does not affect the output before the next edge.
        @(negedge clock);
        address = 3'd1;
        #1;
        checks++;
        if (parallel_out !== 8'h78) begin
            errors++;
            $display("FAIL cap_latency: got %h expected %h", parallel_out, 8'h78);
        end
        @(negedge clock);
        checks++;
        if (parallel_out !== 8'h56) begin
            errors++;
            $display("FAIL cap_b1: got %h expected %h", parallel_out, 8'h56);
        end
        expect_byte("cap_b2", 3'd2, 8'h34);
        expect_byte("cap_b3", 3'd3, 8'h12);
        expect_byte("cap_status", 3'd4, 8'h21);
        expect_byte("cap_unused", 3'd6, 8'h00);
        expect_bit("cap_fresh", fresh, 1'b1);
        pulse_ack();
        expect_byte("cap_ack_status", 3'd4, 8'h01);
        expect_bit("cap_ack_fresh", fresh, 1'b0);
    endtask

    task automatic test_reject();
        send_frame(BAD_HDR, 32'hDEADBEEF);
        expect_byte("rej_b0", 3'd0, 8'h78);
        expect_byte("rej_b3", 3'd3, 8'h12);
        expect_byte("rej_count1", 3'd5, 8'h01);
        for (int i = 0; i < 300; i++) send_frame(BAD_HDR, 32'hDEADBEEF);
        expect_byte("rej_saturate", 3'd5, 8'hFF);
        expect_byte("rej_status", 3'd4, 8'h01);
    endtask

    task automatic test_freeze();
        @(negedge clock);
        freeze = 1'b1;
        send_frame(GOOD_HDR, 32'hAAAA0001);
        expect_byte("frz_visible", 3'd0, 8'h78);
        expect_byte("frz_status_a", 3'd4, 8'h52);
        send_frame(GOOD_HDR, 32'hBBBB0002);
        expect_byte("frz_status_b", 3'd4, 8'hD3);
        expect_bit("frz_overrun", overrun, 1'b1);
        expect_bit("frz_no_fresh", fresh, 1'b0);
        @(negedge clock);
        freeze = 1'b0;
        @(negedge clock);
        expect_bit("frz_promote_fresh", fresh, 1'b1);
        expect_byte("frz_b0", 3'd0, 8'h02);
        expect_byte("frz_b2", 3'd2, 8'hBB);
        expect_byte("frz_status_rel", 3'd4, 8'hA3);
        pulse_ack();
        expect_byte("frz_status_ack", 3'd4, 8'h03);
    endtask

    task automatic test_coincide();
        @(negedge clock);
        freeze = 1'b1;
        send_frame(GOOD_HDR, 32'hDDDD0004);
        expect_byte("coin_status_pend", 3'd4, 8'h54);
        // Freeze falls in the same cycle frame C is accepted.
        @(negedge clock);
        freeze        = 1'b0;
        frame_full    = 1'b1;
        frame_header  = GOOD_HDR;
        frame_payload = 32'hCCCC0003;
        @(negedge clock);
        frame_full = 1'b0;
        expect_bit("coin_overrun", overrun, 1'b1);
        expect_bit("coin_fresh", fresh, 1'b1);
        expect_byte("coin_b0", 3'd0, 8'h03);
        expect_byte("coin_b3", 3'd3, 8'hCC);
        expect_byte("coin_status", 3'd4, 8'hA5);
        pulse_ack();
        expect_byte("coin_status_ack", 3'd4, 8'h05);
        // ack coincides with an accept; a read of byte 0 races the update.
        @(negedge clock);
        address       = 3'd0;
        ack           = 1'b1;
        frame_full    = 1'b1;
        frame_payload = 32'hEEEE0005;
        @(negedge clock);
        ack        = 1'b0;
        frame_full = 1'b0;
        checks++;
        if (parallel_out !== 8'h03) begin
            errors++;
            $display("FAIL coin_read_old: got %h expected %h", parallel_out, 8'h03);
        end
        @(negedge clock);
        checks++;
        if (parallel_out !== 8'h05) begin
            errors++;
            $display("FAIL coin_read_new: got %h expected %h", parallel_out, 8'h05);
        end
        expect_bit("coin_ack_fresh_wins", fresh, 1'b1);
        expect_bit("coin_ack_overrun", overrun, 1'b0);
        expect_byte("coin_status_e", 3'd4, 8'h26);
    endtask

    task automatic test_wrap_and_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) send_frame(GOOD_HDR, 32'(i));
        expect_byte("wrap_status", 3'd4, 8'h21);
        expect_byte("wrap_b0", 3'd0, 8'h10);
        // Reset while frame_full stays high.
        @(negedge clock);
        frame_full    = 1'b1;
        frame_header  = GOOD_HDR;
        frame_payload = 32'h11223344;
        @(negedge clock);
        reset = 1'b0;
        #1;
        expect_bit("mid_rst_fresh", fresh, 1'b0);
        expect_bit("mid_rst_overrun", overrun, 1'b0);
        checks++;
        if (parallel_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst_out: got %h expected %h", parallel_out, 8'h00);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        frame_full = 1'b0;
        expect_byte("post_rst_status", 3'd4, 8'h21);
        expect_byte("post_rst_b0", 3'd0, 8'h44);
        expect_byte("post_rst_b3", 3'd3, 8'h11);
        expect_byte("post_rst_reject", 3'd5, 8'h00);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_reject();
        test_freeze();
        test_coincide();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
